// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master round-robin arbiter for the 16-bit memory-mapped
//                bus. The owner is preempted after MAX_HOLD consecutive
//                accepted transfers while the other master waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req0,
  input  logic [15:0] Addr0,
  input  logic [15:0] Wdata0,
  input  logic        W0,
  output logic        Gnt0,
  output logic        Rvalid0,
  input  logic        Req1,
  input  logic [15:0] Addr1,
  input  logic [15:0] Wdata1,
  input  logic        W1,
  output logic        Gnt1,
  output logic        Rvalid1,
  output logic [15:0] Rdata,
  output logic [15:0] ADDR,
  output logic [15:0] DOUT,
  output logic        W,
  input  logic [15:0] DIN
);

  // Counter is wide enough to hold MAX_HOLD itself; it saturates there.
  localparam int             c_cw   = $clog2(MAX_HOLD + 1);
  localparam logic [c_cw:0]  c_max  = (c_cw + 1)'(MAX_HOLD);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_own0 = 2'd1;
  localparam logic [1:0] c_own1 = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic            r_last;
  logic [c_cw-1:0] r_count;
  logic [c_cw:0]   w_cnt_inc;
  logic            w_limit;
  logic            r_gnt0;
  logic            r_gnt1;
  logic            r_rvalid0;
  logic            r_rvalid1;
  logic            w_acc0;
  logic            w_acc1;

  assign w_acc0    = Req0 & r_gnt0;
  assign w_acc1    = Req1 & r_gnt1;
  // One extra bit so the comparison with MAX_HOLD cannot overflow.
  assign w_cnt_inc = {1'b0, r_count} + 1'b1;
  assign w_limit   = (w_cnt_inc >= c_max);

  assign Gnt0    = r_gnt0;
  assign Gnt1    = r_gnt1;
  assign Rvalid0 = r_rvalid0;
  assign Rvalid1 = r_rvalid1;
  assign Rdata   = DIN;

  // Next-owner decision: round-robin on ties, hand over on release or hold limit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle: begin
        if (Req0 && Req1) w_next = r_last ? c_own0 : c_own1;
        else if (Req0)    w_next = c_own0;
        else if (Req1)    w_next = c_own1;
      end
      c_own0: begin
        if (!Req0)                w_next = Req1 ? c_own1 : c_idle;
        else if (Req1 && w_limit) w_next = c_own1;
      end
      c_own1: begin
        if (!Req1)                w_next = Req0 ? c_own0 : c_idle;
        else if (Req0 && w_limit) w_next = c_own0;
      end
      default: w_next = c_idle;
    endcase
  end

  // Ownership state, grant flops, round-robin pointer and hold counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= c_idle;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_last  <= 1'b1;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_gnt0  <= (w_next == c_own0);
      r_gnt1  <= (w_next == c_own1);
      if (w_next != r_state) begin
        r_count <= '0;
        if (w_next == c_own0) r_last <= 1'b0;
        if (w_next == c_own1) r_last <= 1'b1;
      end else if ((w_acc0 || w_acc1) && ({1'b0, r_count} != c_max)) begin
        r_count <= w_cnt_inc[c_cw-1:0];
      end
    end
  end

  // Read-valid follows an accepted read by one cycle (synchronous slaves).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_acc0 & ~W0;
      r_rvalid1 <= w_acc1 & ~W1;
    end
  end

  // Only an accepted transfer drives the bus; otherwise it is parked at zero.
  always_comb begin
    ADDR = 16'h0000;
    DOUT = 16'h0000;
    W    = 1'b0;
    if (w_acc0) begin
      ADDR = Addr0;
      DOUT = Wdata0;
      W    = W0;
    end else if (w_acc1) begin
      ADDR = Addr1;
      DOUT = Wdata1;
      W    = W1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter: vector table, directed
//                corner sequences and randomized traffic against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int MAX_HOLD = 8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0, Req1, W0, W1;
  logic [15:0] Addr0, Wdata0, Addr1, Wdata1;
  logic        Gnt0, Gnt1, Rvalid0, Rvalid1, W;
  logic [15:0] Rdata, ADDR, DOUT, DIN;
  logic [15:0] r_din_addr = 16'h0000;

  int n_checks = 0;
  int n_errors = 0;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Addr0(Addr0), .Wdata0(Wdata0), .W0(W0), .Gnt0(Gnt0), .Rvalid0(Rvalid0),
    .Req1(Req1), .Addr1(Addr1), .Wdata1(Wdata1), .W1(W1), .Gnt1(Gnt1), .Rvalid1(Rvalid1),
    .Rdata(Rdata), .ADDR(ADDR), .DOUT(DOUT), .W(W), .DIN(DIN)
  );

  always #5 Clock = ~Clock;

  // Synchronous slave: data for an address appears the cycle after it.
  function automatic logic [15:0] slave_f(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  always @(posedge Clock) r_din_addr <= ADDR;
  assign DIN = slave_f(r_din_addr);

  typedef struct {
    logic r0, r1, w0, w1;
    logic [15:0] a0, d0, a1, d1;
    logic g0, g1;
    logic [15:0] eaddr, edout;
    logic ew, rv0, rv1, chk;
    logic [15:0] erd;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic r0, r1, w0, w1,
                              input logic [15:0] a0, d0, a1, d1,
                              input logic g0, g1,
                              input logic [15:0] eaddr, edout,
                              input logic ew, rv0, rv1, chk,
                              input logic [15:0] erd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.eaddr = eaddr; v.edout = edout;
    v.ew = ew; v.rv0 = rv0; v.rv1 = rv1; v.chk = chk; v.erd = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, r1, w0, w1, input logic [15:0] a0, d0, a1, d1);
    Req0 = r0; Req1 = r1; W0 = w0; W1 = w1;
    Addr0 = a0; Wdata0 = d0; Addr1 = a1; Wdata1 = d1;
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge Clock);
    #1;
    check("rst.gnt0", Gnt0, 0);
    check("rst.gnt1", Gnt1, 0);
    check("rst.w", W, 0);
    check("rst.rv", {Rvalid0, Rvalid1}, 0);
    Reset = 1'b0;
  endtask

  // Reference model state for random traffic.
  int          m_own;    // -1 none, else owning master
  int          m_last;
  int          m_held;
  logic        m_rv [2];
  logic [15:0] m_rd;
  int          m_wait [2];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Single-master read, master-1 write, handovers and return to idle.
    tbl[0]  = mk(1,0,0,0, 16'h0005,0,0,0,           0,0, 16'h0000,16'h0000, 0,0,0,0, 0);
    tbl[1]  = mk(1,0,0,0, 16'h0005,0,0,0,           1,0, 16'h0005,16'h0000, 0,0,0,0, 0);
    tbl[2]  = mk(0,0,0,0, 0,0,0,0,                  1,0, 16'h0000,16'h0000, 0,1,0,1, slave_f(16'h0005));
    tbl[3]  = mk(0,1,0,1, 0,0,16'h1000,16'h01AA,    0,0, 16'h0000,16'h0000, 0,0,0,0, 0);
    tbl[4]  = mk(0,1,0,1, 0,0,16'h1000,16'h01AA,    0,1, 16'h1000,16'h01AA, 1,0,0,0, 0);
    tbl[5]  = mk(1,0,1,0, 16'h0020,16'h1234,0,0,    0,1, 16'h0000,16'h0000, 0,0,0,0, 0);
    tbl[6]  = mk(1,0,1,0, 16'h0020,16'h1234,0,0,    1,0, 16'h0020,16'h1234, 1,0,0,0, 0);
    tbl[7]  = mk(1,1,0,0, 16'h0033,0,16'h0044,0,    1,0, 16'h0033,16'h0000, 0,0,0,0, 0);
    tbl[8]  = mk(0,1,0,0, 0,0,16'h0044,0,           1,0, 16'h0000,16'h0000, 0,1,0,1, slave_f(16'h0033));
    tbl[9]  = mk(0,1,0,0, 0,0,16'h0044,0,           0,1, 16'h0044,16'h0000, 0,0,0,0, 0);
    tbl[10] = mk(0,0,0,0, 0,0,0,0,                  0,1, 16'h0000,16'h0000, 0,0,1,1, slave_f(16'h0044));
    tbl[11] = mk(0,0,0,0, 0,0,0,0,                  0,0, 16'h0000,16'h0000, 0,0,0,0, 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1,
            tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      #4;
      check($sformatf("vec%0d.gnt0", i), Gnt0, tbl[i].g0);
      check($sformatf("vec%0d.gnt1", i), Gnt1, tbl[i].g1);
      check($sformatf("vec%0d.addr", i), ADDR, tbl[i].eaddr);
      check($sformatf("vec%0d.dout", i), DOUT, tbl[i].edout);
      check($sformatf("vec%0d.w", i), W, tbl[i].ew);
      check($sformatf("vec%0d.rv0", i), Rvalid0, tbl[i].rv0);
      check($sformatf("vec%0d.rv1", i), Rvalid1, tbl[i].rv1);
      if (tbl[i].chk) check($sformatf("vec%0d.rdata", i), Rdata, tbl[i].erd);
      next_cycle();
    end

    // Contention from reset: master 0 gets exactly MAX_HOLD transfers, then master 1.
    do_reset();
    drive(1, 1, 0, 0, 16'h0100, 0, 16'h0200, 0);
    #4;
    check("hold.idle.gnt", {Gnt0, Gnt1}, 2'b00);
    for (int k = 1; k <= MAX_HOLD; k++) begin
      next_cycle();
      #4;
      check($sformatf("hold.own0.%0d", k), {Gnt0, Gnt1}, 2'b10);
    end
    next_cycle();
    drive(0, 1, 0, 0, 16'h0100, 0, 16'h0200, 0);
    #4;
    check("hold.switch", {Gnt0, Gnt1}, 2'b01);
    check("hold.switch.addr", ADDR, 16'h0200);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    check("hold.release", {Gnt0, Gnt1}, 2'b01);
    next_cycle();
    drive(1, 1, 0, 0, 16'h0100, 0, 16'h0200, 0);
    #4;
    check("hold.idle2", {Gnt0, Gnt1}, 2'b00);
    next_cycle();
    #4;
    check("hold.tie2", {Gnt0, Gnt1}, 2'b10);
    next_cycle();

    // Reset in the very cycle a read is accepted.
    do_reset();
    drive(1, 0, 0, 0, 16'h0007, 0, 0, 0);
    next_cycle();
    #4;
    check("arst.accept", {Gnt0, ADDR}, {1'b1, 16'h0007});
    #1 Reset = 1'b1;
    #1;
    check("arst.gnt", {Gnt0, Gnt1}, 2'b00);
    check("arst.bus", {W, ADDR, DOUT}, 33'h0);
    check("arst.rv", {Rvalid0, Rvalid1}, 2'b00);
    next_cycle();
    Reset = 1'b0;
    #3;
    check("arst.norv", {Rvalid0, Rvalid1, Gnt0}, 3'b000);
    next_cycle();
    #4;
    check("arst.regrant", {Gnt0, Rvalid0, ADDR}, {1'b1, 1'b0, 16'h0007});
    next_cycle();

    // Randomized traffic against the behavioural model.
    do_reset();
    m_own = -1; m_last = 1; m_held = 0;
    m_rv[0] = 0; m_rv[1] = 0; m_rd = 0;
    m_wait[0] = 0; m_wait[1] = 0;
    for (int c = 0; c < 10000; c++) begin
      logic        rq [2];
      logic        wr [2];
      logic [15:0] ad [2];
      logic [15:0] wd [2];
      logic        acc;
      int          nxt;
      logic [15:0] e_addr, e_dout;
      logic        e_w;
      for (int m = 0; m < 2; m++) begin
        rq[m] = ($urandom_range(0, 9) < 7);
        wr[m] = $urandom_range(0, 1) == 1;
        ad[m] = 16'($urandom);
        wd[m] = 16'($urandom);
      end
      drive(rq[0], rq[1], wr[0], wr[1], ad[0], wd[0], ad[1], wd[1]);
      #4;
      acc = (m_own >= 0) && rq[m_own];
      e_addr = acc ? ad[m_own] : 16'h0;
      e_dout = acc ? wd[m_own] : 16'h0;
      e_w    = acc ? wr[m_own] : 1'b0;
      check("rnd.gnt0", Gnt0, m_own == 0);
      check("rnd.gnt1", Gnt1, m_own == 1);
      check("rnd.addr", ADDR, e_addr);
      check("rnd.dout", DOUT, e_dout);
      check("rnd.w", W, e_w);
      check("rnd.rv0", Rvalid0, m_rv[0]);
      check("rnd.rv1", Rvalid1, m_rv[1]);
      if (m_rv[0] || m_rv[1]) check("rnd.rdata", Rdata, m_rd);
      check("rnd.excl", Gnt0 & Gnt1, 0);
      check("rnd.wlegal", W & ~((Req0 & Gnt0) | (Req1 & Gnt1)), 0);
      for (int m = 0; m < 2; m++) begin
        if (rq[m] && m_own != m) m_wait[m]++;
        else m_wait[m] = 0;
        check($sformatf("rnd.wait%0d", m), m_wait[m] > MAX_HOLD + 1, 0);
      end
      // Model update for the coming edge.
      m_rv[0] = acc && m_own == 0 && !wr[0];
      m_rv[1] = acc && m_own == 1 && !wr[1];
      if (acc) m_rd = slave_f(ad[m_own]);
      if (m_own < 0) begin
        if (rq[0] && rq[1]) nxt = 1 - m_last;
        else if (rq[0])     nxt = 0;
        else if (rq[1])     nxt = 1;
        else                nxt = -1;
      end else if (!rq[m_own]) begin
        nxt = rq[1 - m_own] ? 1 - m_own : -1;
      end else if (rq[1 - m_own] && m_held + 1 >= MAX_HOLD) begin
        nxt = 1 - m_own;
      end else begin
        nxt = m_own;
      end
      if (nxt != m_own) begin
        m_held = 0;
        if (nxt >= 0) m_last = nxt;
      end else if (acc) begin
        m_held++;
      end
      m_own = nxt;
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
